conv_window_fetch: RTL and testbench

- Downstream reader of the 4096x10 conv feature-map RAM.
- Walks a stored IMG_W x IMG_H map with stride 1, issuing read addresses and capturing the 1-cycle-latency read data.
- Assembles each 3x3 window into a packed 90-bit word for the depthwise/pointwise conv datapath.
- Output side uses a valid/ready handshake; one window in flight at a time.

---
 rtl/conv_pkg.sv | 17 +
 rtl/conv_window_fetch_if.sv | 30 +++
 rtl/conv_tap_addr_gen.sv | 53 +++++
 rtl/conv_window_fetch.sv | 150 +++++++++++++++
 tb/tb_conv_window_fetch.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the 3x3 conv window fetcher.
package conv_pkg;

  localparam int DATA_W = 10;
  localparam int ADDR_W = 12;
  localparam int KERNEL = 3;
  localparam int TAPS   = KERNEL * KERNEL;
  localparam int TAP_W  = $clog2(TAPS + 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DONE
  } state_t;

endpackage

// File: rtl/conv_window_fetch_if.sv
// Window output stream: packed 3x3 window plus top-left coordinates, valid/ready handshake.
interface conv_window_fetch_if #(
  parameter int DATA_W = 10,
  parameter int RW     = 6,
  parameter int CW     = 6
);

  logic [9*DATA_W-1:0] window;
  logic                valid;
  logic                ready;
  logic [RW-1:0]       row;
  logic [CW-1:0]       col;

  modport master (
    output window,
    output valid,
    output row,
    output col,
    input  ready
  );

  modport slave (
    input  window,
    input  valid,
    input  row,
    input  col,
    output ready
  );

endinterface

// File: rtl/conv_tap_addr_gen.sv
// Combinational tap index -> RAM address for a 3x3 window; with CONV_ZERO_PAD_EN
// also flags taps that fall outside the map (same padding).
module conv_tap_addr_gen #(
  parameter int IMG_W  = 64,
`ifdef CONV_ZERO_PAD_EN
  parameter int IMG_H  = 64,
`endif
  parameter int ADDR_W = 12,
  parameter int RW     = 6,
  parameter int CW     = 6,
  parameter int TAP_W  = 4
) (
  input  logic [TAP_W-1:0]  i_tap,
  input  logic [RW-1:0]     i_row,
  input  logic [CW-1:0]     i_col,
  input  logic [ADDR_W-1:0] i_base,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_inRange
);

  import conv_pkg::*;

`ifdef CONV_ZERO_PAD_EN
  localparam int OFFSET = 1;
`else
  localparam int OFFSET = 0;
`endif

  int w_ky;
  int w_kx;
  int w_r;
  int w_c;
  int w_off;

  // Coordinates may go negative in the padded build; the address is only
  // used when the tap is in range, so modular truncation is harmless.
  always_comb begin
    w_ky  = int'(i_tap) / KERNEL;
    w_kx  = int'(i_tap) % KERNEL;
    w_r   = int'(i_row) + w_ky - OFFSET;
    w_c   = int'(i_col) + w_kx - OFFSET;
    w_off = w_r * IMG_W + w_c;
  end

  assign o_addr = i_base + w_off[ADDR_W-1:0];

`ifdef CONV_ZERO_PAD_EN
  assign o_inRange = (w_r >= 0) && (w_r < IMG_H) && (w_c >= 0) && (w_c < IMG_W);
`else
  assign o_inRange = 1'b1;
`endif

endmodule

// File: rtl/conv_window_fetch.sv
// Raster-scans a feature map in RAM, assembling 3x3 windows for the conv datapath.
// Define CONV_ZERO_PAD_EN for same padding (IMG_H x IMG_W windows, zero taps off-map).
module conv_window_fetch #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int ADDR_W = conv_pkg::ADDR_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [ADDR_W-1:0]   i_baseAddr,
  output logic [ADDR_W-1:0]   o_rdAddr,
  input  logic [DATA_W-1:0]   i_rdData,
  conv_window_fetch_if.master o_win,
  output logic                o_busy,
  output logic                o_done
);

  import conv_pkg::*;

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

`ifdef CONV_ZERO_PAD_EN
  localparam int SPAN = 0;
`else
  localparam int SPAN = KERNEL - 1;
`endif

  localparam logic [RW-1:0]    LAST_ROW = RW'(IMG_H - 1 - SPAN);
  localparam logic [CW-1:0]    LAST_COL = CW'(IMG_W - 1 - SPAN);
  localparam logic [TAP_W-1:0] TAP_END  = TAP_W'(TAPS);

  state_t              r_state;
  state_t              w_nextState;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_rdAddr;
  logic [ADDR_W-1:0]   w_tapAddr;
  logic [TAP_W-1:0]    r_tap;
  logic [RW-1:0]       r_row;
  logic [CW-1:0]       r_col;
  logic [9*DATA_W-1:0] r_window;
  logic                r_prevInRange;
  logic                w_tapInRange;
  logic                w_drive;
  logic                w_accept;
  logic                w_lastWin;
  logic [DATA_W-1:0]   w_pix;

  conv_tap_addr_gen #(
    .IMG_W  (IMG_W),
`ifdef CONV_ZERO_PAD_EN
    .IMG_H  (IMG_H),
`endif
    .ADDR_W (ADDR_W),
    .RW     (RW),
    .CW     (CW),
    .TAP_W  (TAP_W)
  ) u_addrGen (
    .i_tap     (r_tap),
    .i_row     (r_row),
    .i_col     (r_col),
    .i_base    (r_base),
    .o_addr    (w_tapAddr),
    .o_inRange (w_tapInRange)
  );

  assign w_accept  = (r_state == HOLD) && o_win.ready;
  assign w_lastWin = (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign w_drive   = (r_state == FETCH) && (r_tap < TAP_END) && w_tapInRange;
  assign w_pix     = r_prevInRange ? i_rdData : '0;

  // The address bus is a live mux so the RAM sees each tap in its own cycle;
  // r_rdAddr remembers the last driven value for the hold cases.
  assign o_rdAddr = w_drive ? w_tapAddr : r_rdAddr;

  assign o_win.window = r_window;
  assign o_win.valid  = (r_state == HOLD);
  assign o_win.row    = r_row;
  assign o_win.col    = r_col;
  assign o_busy       = (r_state == FETCH) || (r_state == HOLD);
  assign o_done       = (r_state == DONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:  if (i_start) w_nextState = FETCH;
      FETCH: if (r_tap == TAP_END) w_nextState = HOLD;
      HOLD:  if (w_accept) w_nextState = w_lastWin ? DONE : FETCH;
      DONE:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_base        <= '0;
      r_rdAddr      <= '0;
      r_tap         <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_window      <= '0;
      r_prevInRange <= 1'b1;
    end else begin
      r_rdAddr <= o_rdAddr;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_base <= i_baseAddr;
            r_row  <= '0;
            r_col  <= '0;
            r_tap  <= '0;
          end
        end
        FETCH: begin
          r_tap         <= r_tap + TAP_W'(1);
          r_prevInRange <= w_tapInRange;
          // Data arriving in tap cycle t belongs to the address issued at t-1.
          for (int k = 0; k < TAPS; k++) begin
            if (r_tap == TAP_W'(k + 1)) begin
              r_window[k*DATA_W +: DATA_W] <= w_pix;
            end
          end
        end
        HOLD: begin
          if (w_accept) begin
            r_tap <= '0;
            if (r_col < LAST_COL) begin
              r_col <= r_col + CW'(1);
            end else begin
              r_col <= '0;
              r_row <= r_row + RW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_fetch.sv
// Directed bench for conv_window_fetch on a 4x4 map with RAM model mem[a] = a & 0x3FF.
// Expectations for the padded build are selected with CONV_ZERO_PAD_EN.
module tb_conv_window_fetch;

  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
`ifdef CONV_ZERO_PAD_EN
  localparam int NWIN  = 16;
  localparam int NCOLS = 4;
`else
  localparam int NWIN  = 4;
  localparam int NCOLS = 2;
`endif

  typedef logic [11:0] addr9_t [9];
  typedef logic [9:0]  pix9_t  [9];

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [11:0] i_baseAddr;
  logic [11:0] o_rdAddr;
  logic [9:0]  i_rdData = '0;
  logic        o_busy;
  logic        o_done;

  int nCompared   = 0;
  int nMismatched = 0;

  conv_window_fetch_if #(.DATA_W(10), .RW(2), .CW(2)) win ();

  conv_window_fetch #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .DATA_W (10),
    .ADDR_W (12)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_baseAddr (i_baseAddr),
    .o_rdAddr   (o_rdAddr),
    .i_rdData   (i_rdData),
    .o_win      (win.master),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) i_rdData <= o_rdAddr[9:0];

`ifdef CONV_ZERO_PAD_EN
  addr9_t addrFirst = '{12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd1, 12'd1, 12'd4, 12'd5};
  pix9_t  pixFirst  = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd1, 10'd0, 10'd4, 10'd5};
  addr9_t addrWrap  = '{12'd0, 12'd0, 12'd0, 12'd0, 12'd4094, 12'd4095, 12'd4095, 12'd2, 12'd3};
  pix9_t  pixWrap   = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd1022, 10'd1023, 10'd0, 10'd2, 10'd3};
`else
  addr9_t addrFirst = '{12'd0, 12'd1, 12'd2, 12'd4, 12'd5, 12'd6, 12'd8, 12'd9, 12'd10};
  pix9_t  pixFirst  = '{10'd0, 10'd1, 10'd2, 10'd4, 10'd5, 10'd6, 10'd8, 10'd9, 10'd10};
  addr9_t addrWrap  = '{12'd4094, 12'd4095, 12'd0, 12'd2, 12'd3, 12'd4, 12'd6, 12'd7, 12'd8};
  pix9_t  pixWrap   = '{10'd1022, 10'd1023, 10'd0, 10'd2, 10'd3, 10'd4, 10'd6, 10'd7, 10'd8};
  pix9_t  pixScan [4] = '{
    '{10'd0, 10'd1, 10'd2,  10'd4,  10'd5,  10'd6,  10'd8,  10'd9,  10'd10},
    '{10'd1, 10'd2, 10'd3,  10'd5,  10'd6,  10'd7,  10'd9,  10'd10, 10'd11},
    '{10'd4, 10'd5, 10'd6,  10'd8,  10'd9,  10'd10, 10'd12, 10'd13, 10'd14},
    '{10'd5, 10'd6, 10'd7,  10'd9,  10'd10, 10'd11, 10'd13, 10'd14, 10'd15}
  };
`endif

  function automatic logic [89:0] pack(input pix9_t p);
    logic [89:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*10 +: 10] = p[k];
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic [11:0] base, input logic ready);
    i_start    = start;
    i_baseAddr = base;
    win.ready  = ready;
  endtask

  // Entered on the negedge of FETCH tap 0; leaves on the negedge of the first HOLD cycle.
  task automatic fetchFirst(input string tag, input addr9_t a, input pix9_t p);
    for (int k = 0; k < 9; k++) begin
      checkOutput($sformatf("%s_rdAddr%0d", tag, k), 128'(o_rdAddr), 128'(a[k]));
      @(negedge i_clk);
    end
    checkOutput({tag, "_rdAddrHold"}, 128'(o_rdAddr), 128'(a[8]));
    checkOutput({tag, "_validEarly"}, 128'(win.valid), 128'(1'b0));
    @(negedge i_clk);
    checkOutput({tag, "_valid"}, 128'(win.valid), 128'(1'b1));
    checkOutput({tag, "_window"}, 128'(win.window), 128'(pack(p)));
    checkOutput({tag, "_rowcol"}, 128'({win.row, win.col}), 128'(4'b0000));
  endtask

  task automatic waitValid(output int cycles);
    cycles = 0;
    do begin
      @(negedge i_clk);
      cycles++;
      i_start = 1'b0;
    end while (!win.valid && cycles < 40);
  endtask

  task automatic finishScan(input string tag, input logic checkWindows);
    int cyc;
    for (int w = 1; w < NWIN; w++) begin
      waitValid(cyc);
      checkOutput($sformatf("%s_lat%0d", tag, w), 128'(cyc), 128'(11));
      checkOutput($sformatf("%s_rowcol%0d", tag, w), 128'({win.row, win.col}),
                  128'({2'(w / NCOLS), 2'(w % NCOLS)}));
`ifndef CONV_ZERO_PAD_EN
      if (checkWindows) begin
        checkOutput($sformatf("%s_window%0d", tag, w), 128'(win.window), 128'(pack(pixScan[w])));
      end
`endif
    end
    @(negedge i_clk);
    checkOutput({tag, "_doneBusyValid"}, 128'({o_done, o_busy, win.valid}), 128'(3'b100));
    @(negedge i_clk);
    checkOutput({tag, "_donePulse"}, 128'({o_done, o_busy}), 128'(2'b00));
  endtask

  initial begin
    int cyc;
    logic [106:0] holdExp;

    i_rst = 1'b1;
    applyStimulus(1'b0, 12'd0, 1'b1);
    repeat (2) @(negedge i_clk);
    checkOutput("rst_rdAddr", 128'(o_rdAddr), 128'(0));
    checkOutput("rst_window", 128'(win.window), 128'(0));
    checkOutput("rst_flags", 128'({win.valid, o_busy, o_done}), 128'(0));
    checkOutput("rst_rowcol", 128'({win.row, win.col}), 128'(0));
    i_rst = 1'b0;
    @(negedge i_clk);

    // Full scan from base 0, with a start pulse injected while busy.
    applyStimulus(1'b1, 12'd0, 1'b1);
    @(negedge i_clk);
    i_start = 1'b0;
    checkOutput("scan_busy", 128'(o_busy), 128'(1'b1));
    fetchFirst("scan", addrFirst, pixFirst);
    applyStimulus(1'b1, 12'd100, 1'b1);
    finishScan("scan", 1'b1);

    // Backpressure on window (0,0).
    applyStimulus(1'b1, 12'd0, 1'b0);
    waitValid(cyc);
    checkOutput("bp_lat", 128'(cyc), 128'(11));
    holdExp = {1'b1, 2'd0, 2'd0, pack(pixFirst), addrFirst[8]};
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("bp_hold%0d", i),
                  128'({win.valid, win.row, win.col, win.window, o_rdAddr}), 128'(holdExp));
      @(negedge i_clk);
    end
    win.ready = 1'b1;
    @(negedge i_clk);
    checkOutput("bp_accept", 128'({win.valid, win.row, win.col}), 128'({1'b0, 2'd0, 2'd1}));

    // Reset during FETCH cycle 5 of window (0,1).
    repeat (5) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    checkOutput("midrst_outs",
                128'({o_rdAddr, win.valid, o_busy, o_done, win.row, win.col}), 128'(0));
    checkOutput("midrst_window", 128'(win.window), 128'(0));
    i_rst = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("midrst_noDone", 128'({o_done, o_busy}), 128'(0));

    // Restart with a base that wraps the 12-bit address space.
    applyStimulus(1'b1, 12'd4094, 1'b1);
    @(negedge i_clk);
    i_start = 1'b0;
    fetchFirst("wrap", addrWrap, pixWrap);
    finishScan("wrap", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
